// File: rtl/perf_trace_unit_pkg.sv
// Shared types and constants for the performance trace unit.
// A record is four 32-bit fields packed with W0 in the most significant slot.
package perf_trace_unit_pkg;

   localparam int FIELD_W   = 32;
   localparam int REC_WORDS = 4;
   localparam int REC_W     = FIELD_W * REC_WORDS;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } trace_state_t;

   localparam logic [1:0] W0 = 2'd0;
   localparam logic [1:0] W1 = 2'd1;
   localparam logic [1:0] W2 = 2'd2;
   localparam logic [1:0] W3 = 2'd3;

   function automatic logic [FIELD_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                   input logic [1:0]       idx);
      logic [FIELD_W-1:0] word;
      case (idx)
         W0:      word = rec[4*FIELD_W-1 -: FIELD_W];
         W1:      word = rec[3*FIELD_W-1 -: FIELD_W];
         W2:      word = rec[2*FIELD_W-1 -: FIELD_W];
         default: word = rec[FIELD_W-1 -: FIELD_W];
      endcase
      return word;
   endfunction

endpackage

// File: rtl/perf_trace_unit_trace_fifo.sv
// Synchronous record FIFO with wrap-bit pointers for full/empty.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module trace_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is never reset; the reader only sees it through the empty flag.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/perf_trace_unit.sv
// Cycle/stall/flush trace collector: snapshots counters into a record FIFO
// and streams each record out as four words with a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no record on the output; wait for a non-empty FIFO
// ST_SEND | presenting word word_idx of the FIFO head record
module perf_trace_unit
   import perf_trace_unit_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int MAX_CYCLES = 10
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic        flush_i,
   output logic [31:0] tdata_o,
   output logic        tvalid_o,
   input  logic        tready_i,
   output logic        tlast_o,
   output logic        overflow_o,
   output logic [15:0] drop_cnt_o,
   output logic        done_o
);

   localparam int                 CW        = $clog2(DEPTH) + 1;
   localparam logic [FIELD_W-1:0] CYC_LIMIT = FIELD_W'(MAX_CYCLES);

   logic [FIELD_W-1:0] cyc_cnt;
   logic [FIELD_W-1:0] stall_cnt;
   logic [FIELD_W-1:0] flush_cnt;
   trace_state_t       state;
   logic [1:0]         word_idx;

   logic               traced;
   logic               handshake;
   logic               pop;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic [REC_W-1:0]   push_rec;
   logic [REC_W-1:0]   head_rec;

   assign traced    = start_i && (cyc_cnt < CYC_LIMIT);
   assign handshake = (state == ST_SEND) && tready_i;
   assign pop       = handshake && (word_idx == W3);
   assign drop      = traced && fifo_full && !pop;
   assign push_rec  = {cyc_cnt, pc_i, stall_cnt, flush_cnt};

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_trace_fifo (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .push  (traced && !drop),
      .pop   (pop),
      .wdata (push_rec),
      .rdata (head_rec),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (traced) begin
         cyc_cnt <= cyc_cnt + 1'b1;
         if (stall_i && !branch_i) stall_cnt <= stall_cnt + 1'b1;
         if (flush_i)              flush_cnt <= flush_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
   end

   // After a pop, a record pushed on that same edge is only picked up from
   // IDLE, so no record ever reaches the output on the edge it was written.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= ST_IDLE;
         word_idx <= W0;
      end else begin
         case (state)
            ST_IDLE: begin
               word_idx <= W0;
               if (!fifo_empty) state <= ST_SEND;
            end
            ST_SEND: begin
               if (handshake) begin
                  if (word_idx == W3) begin
                     word_idx <= W0;
                     if (fifo_count <= CW'(1)) state <= ST_IDLE;
                  end else begin
                     word_idx <= word_idx + 1'b1;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               word_idx <= W0;
            end
         endcase
      end
   end

   assign tvalid_o = (state == ST_SEND);
   assign tdata_o  = tvalid_o ? rec_word(head_rec, word_idx) : '0;
   assign tlast_o  = tvalid_o && (word_idx == W3);
   assign done_o   = (cyc_cnt == CYC_LIMIT) && fifo_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_perf_trace_unit.sv
// Self-checking bench for perf_trace_unit: a queue-based reference model
// scores every cycle, directed tables and sequences cover the corner cases.
module tb_perf_trace_unit;

   localparam int DEPTH = 4;
   localparam int MAXC  = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] pc;
   logic        stall;
   logic        branch;
   logic        flush;
   logic        tready;
   logic [31:0] tdata_o;
   logic        tvalid_o;
   logic        tlast_o;
   logic        overflow_o;
   logic [15:0] drop_cnt_o;
   logic        done_o;

   always #5 clk = ~clk;

   perf_trace_unit #(
      .DEPTH      (DEPTH),
      .MAX_CYCLES (MAXC)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .pc_i       (pc),
      .stall_i    (stall),
      .branch_i   (branch),
      .flush_i    (flush),
      .tdata_o    (tdata_o),
      .tvalid_o   (tvalid_o),
      .tready_i   (tready),
      .tlast_o    (tlast_o),
      .overflow_o (overflow_o),
      .drop_cnt_o (drop_cnt_o),
      .done_o     (done_o)
   );

   typedef struct {
      logic [3:0][31:0] w;
      int               pe;
   } rec_t;

   typedef struct {
      bit          stall;
      bit          branch;
      bit          flush;
      logic [31:0] exp_w2;
      logic [31:0] exp_w3;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;

   // reference model state
   rec_t        mq[$];
   logic [31:0] mcyc, mstall, mflush;
   int          mwidx, mdrop, edge_no;
   bit          movf;
   bit          prev_valid, prev_hs, prev_last;
   logic [31:0] prev_data;
   logic [31:0] got[$];
   int          lasts;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   task automatic set_in(input bit s, input logic [31:0] p, input bit st,
                         input bit br, input bit fl, input bit rd);
      start = s; pc = p; stall = st; branch = br; flush = fl; tready = rd;
   endtask

   task automatic check_outputs();
      if (mq.size() == 0) begin
         chk("valid_when_empty", 32'(tvalid_o), 32'd0);
      end else begin
         if (prev_valid && !prev_hs) begin
            chk("valid_hold", 32'(tvalid_o), 32'd1);
            chk("data_hold", tdata_o, prev_data);
            chk("last_hold", 32'(tlast_o), 32'(prev_last));
         end
         if (mq[0].pe == edge_no) chk("no_bypass", 32'(tvalid_o), 32'd0);
         if (tvalid_o) begin
            chk("word_data", tdata_o, mq[0].w[mwidx]);
            chk("tlast", 32'(tlast_o), 32'(mwidx == 3));
         end
      end
      chk("overflow", 32'(overflow_o), 32'(movf));
      chk("drop_cnt", 32'(drop_cnt_o), 32'(mdrop));
      chk("done", 32'(done_o), 32'((mcyc == 32'(MAXC)) && (mq.size() == 0)));
      prev_valid = tvalid_o;
      prev_data  = tdata_o;
      prev_last  = tlast_o;
      prev_hs    = tvalid_o && tready;
   endtask

   task automatic model_edge(input bit hs);
      rec_t r;
      bit   pop, traced, full;
      edge_no++;
      pop    = hs && (mwidx == 3) && (mq.size() > 0);
      if (hs) mwidx = (mwidx + 1) % 4;
      traced = start && (mcyc < 32'(MAXC));
      full   = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (traced) begin
         r.w[0] = mcyc; r.w[1] = pc; r.w[2] = mstall; r.w[3] = mflush;
         r.pe   = edge_no;
         if (!full || pop) mq.push_back(r);
         else begin
            movf = 1'b1;
            if (mdrop < 65535) mdrop++;
         end
         mcyc = mcyc + 1;
         if (stall && !branch) mstall = mstall + 1;
         if (flush) mflush = mflush + 1;
      end
   endtask

   task automatic cycle();
      bit hs;
      @(negedge clk);
      check_outputs();
      hs = tvalid_o && tready;
      if (hs) begin
         got.push_back(tdata_o);
         if (tlast_o) lasts++;
      end
      @(posedge clk);
      model_edge(hs);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 32'd0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      chk("rst_tdata", tdata_o, 32'd0);
      chk("rst_tvalid", 32'(tvalid_o), 32'd0);
      chk("rst_tlast", 32'(tlast_o), 32'd0);
      chk("rst_overflow", 32'(overflow_o), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      mq.delete(); got.delete();
      mcyc = 0; mstall = 0; mflush = 0; mwidx = 0; mdrop = 0; movf = 0;
      lasts = 0; prev_valid = 0; prev_hs = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit need_max);
      int budget = 0;
      start = need_max; tready = 1'b1;
      while (budget < 300 && !(mq.size() == 0 && (!need_max || mcyc == 32'(MAXC)))) begin
         cycle();
         budget++;
      end
      if (budget >= 300) fail_now("drain_timeout");
      repeat (2) cycle();
   endtask

   // one traced cycle followed by idle cycles so the FIFO never overflows
   task automatic spaced(input logic [31:0] p, input bit st, input bit br,
                         input bit fl, input int gap, input bit tog);
      set_in(1, p, st, br, fl, 1);
      if (tog) tready = edge_no[0];
      cycle();
      for (int g = 1; g < gap; g++) begin
         set_in(0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1);
         if (tog) tready = edge_no[0];
         cycle();
      end
   endtask

   vec_t tbl[MAXC];

   initial begin
      edge_no = 0;
      set_in(0, 32'd0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1;
      do_reset();

      // plain stream: W0 = 0..9, W1 = 0..36
      for (int k = 0; k < MAXC; k++) spaced(32'(4 * k), 0, 0, 0, 6, 0);
      drain(1);
      repeat (4) cycle();
      chk("plain_words", 32'(got.size()), 32'd40);
      chk("plain_done", 32'(done_o), 32'd1);
      chk("plain_drops", 32'(drop_cnt_o), 32'd0);
      if (got.size() == 40)
         for (int k = 0; k < MAXC; k++) begin
            chk("plain_w0", got[4*k], 32'(k));
            chk("plain_w1", got[4*k+1], 32'(4 * k));
         end

      // stall/branch and flush counting table
      for (int k = 0; k < MAXC; k++) begin
         tbl[k].stall  = (k == 2) || (k == 3);
         tbl[k].branch = (k == 2);
         tbl[k].flush  = (k == 1) || (k == 5);
         tbl[k].exp_w2 = (k >= 4) ? 32'd1 : 32'd0;
         tbl[k].exp_w3 = (k >= 6) ? 32'd2 : ((k >= 2) ? 32'd1 : 32'd0);
      end
      do_reset();
      for (int k = 0; k < MAXC; k++)
         spaced($urandom, tbl[k].stall, tbl[k].branch, tbl[k].flush, 6, 0);
      drain(1);
      chk("tbl_words", 32'(got.size()), 32'd40);
      if (got.size() == 40)
         for (int k = 0; k < MAXC; k++) begin
            chk("tbl_w2", got[4*k+2], tbl[k].exp_w2);
            chk("tbl_w3", got[4*k+3], tbl[k].exp_w3);
         end

      // sink stalled for 8 cycles: 4 kept, 4 dropped
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_in(1, 32'(100 + k), 0, 0, 0, 0);
         cycle();
         if (k >= 2) begin
            chk("stall_valid", 32'(tvalid_o), 32'd1);
            chk("stall_tdata", tdata_o, 32'd0);
            chk("stall_tlast", 32'(tlast_o), 32'd0);
         end
      end
      chk("ovf_set", 32'(overflow_o), 32'd1);
      chk("ovf_drop_cnt", 32'(drop_cnt_o), 32'd4);
      drain(0);
      chk("ovf_words", 32'(got.size()), 32'd16);
      if (got.size() == 16)
         for (int k = 0; k < 4; k++) begin
            chk("ovf_w0", got[4*k], 32'(k));
            chk("ovf_w1", got[4*k+1], 32'(100 + k));
         end

      // ready toggling every cycle
      do_reset();
      for (int k = 0; k < MAXC; k++)
         spaced($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 10, 1);
      drain(1);
      chk("tog_words", 32'(got.size()), 32'd40);
      chk("tog_lasts", 32'(lasts), 32'd10);
      if (got.size() == 40)
         for (int k = 0; k < MAXC; k++) chk("tog_w0", got[4*k], 32'(k));

      // asynchronous reset while W1 is on the bus
      do_reset();
      set_in(1, 32'hA0, 0, 0, 0, 0);
      cycle();
      start = 1'b0;
      cycle();
      tready = 1'b1;
      cycle();
      tready = 1'b0;
      chk("midw1_valid", 32'(tvalid_o), 32'd1);
      chk("midw1_data", tdata_o, 32'hA0);
      do_reset();
      drain(1);
      chk("post_rst_first_w0", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, 32'd0);

      // randomized episodes against the model
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         for (int k = 0; k < 80; k++) begin
            set_in(($urandom % 4) != 0, $urandom, 1'($urandom), 1'($urandom),
                   1'($urandom), (ep == 2) ? (($urandom % 4) == 0) : (($urandom % 3) != 0));
            cycle();
         end
         drain(1);
         chk("rand_done", 32'(done_o), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
